uart_tx_frame: RTL
==================

// Module: uart_tx_frame
// PURPOSE
//  Serial UART transmitter: accepts one parallel word, emits a framed bitstream
//  (start, data LSB-first, optional parity, stop bits) on TX_OUT, one bit per CLK.
//  Sits on the TX clock domain (CLK = baud tick clock), mirroring the RX path.
//  Its parity convention matches the RX parity checker: PAR_TYP 0 = even, 1 = odd.
// PARAMETERS
//  DATA_WIDTH  8  data bits per frame (legal 5..9)
//  STOP_BITS   1  number of stop bits (legal 1 or 2)
// PORTS
//  CLK         in   1           clock; one clock, all logic on posedge CLK
//  RST         in   1           reset; synchronous, active-high
//  P_DATA      in   DATA_WIDTH  parallel word to send
//  DATA_VALID  in   1           word request; sampled only when Busy = 0
//  PAR_EN      in   1           1 = insert parity bit after data
//  PAR_TYP     in   1           0 = even parity, 1 = odd parity
//  TX_OUT      out  1           serial line, idles high; registered
//  Busy        out  1           1 = frame in progress, new request not accepted
// BEHAVIOUR
//  Reset: synchronous and active-high on CLK. At the first edge with RST=1:
//   state=IDLE, TX_OUT=1, Busy=0, all holding regs cleared. Applies mid-frame:
//   the frame is abandoned, never resumed or retransmitted.
//  FSM states: IDLE, START, DATA, PARITY, STOP.
//   IDLE:   TX_OUT=1, Busy=0. On an edge with DATA_VALID=1: latch P_DATA,
//           PAR_EN and PAR_TYP into shadow regs; go to START.
//   START:  TX_OUT=0 for 1 cycle -> DATA. Bit counter cleared.
//   DATA:   TX_OUT=shadow[cnt], cnt 0..DATA_WIDTH-1, one bit per cycle (LSB first).
//           After bit DATA_WIDTH-1 -> PARITY if latched PAR_EN, else STOP.
//   PARITY: TX_OUT = (^shadow_data) ^ latched PAR_TYP for 1 cycle -> STOP.
//   STOP:   TX_OUT=1 for STOP_BITS cycles.
//           Busy=0 only in the last stop cycle. At the end of that cycle:
//           DATA_VALID=1 -> latch and go to START (back-to-back, no idle gap);
//           otherwise -> IDLE.
//  Busy=1 in START, DATA and PARITY, and in all STOP cycles except the last.
//  Latency: request accepted at edge k -> start bit on TX_OUT from edge k to k+1.
//  Frame length = 1 + DATA_WIDTH + PAR_EN + STOP_BITS cycles.
//  Ignored inputs:
//   - DATA_VALID while Busy=1 is dropped, not queued.
//   - Changes to P_DATA, PAR_EN or PAR_TYP after acceptance do not affect the
//     frame in flight.
//  Bit counter width = $clog2(DATA_WIDTH); it never wraps past DATA_WIDTH-1.
//  TX_OUT is glitch-free: driven from a flop, never from a combinational mux.
//  Illegal parameter values are undefined; a simulation-only check flags them.
// TESTING (DATA_WIDTH=8, STOP_BITS=1 unless noted)
//  1. P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, one-cycle DATA_VALID ->
//     TX_OUT = 0,1,0,1,0,0,1,0,1,0,1 then idles 1; Busy=1 for 10 cycles.
//  2. P_DATA=0xA5, PAR_EN=1, PAR_TYP=1 -> parity bit 1;
//     P_DATA=0x00, PAR_EN=0 -> 10-cycle frame 0,0x8,1.
//  3. Back-to-back: DATA_VALID held high with 0x01 then 0x80 ->
//     second start bit immediately follows the first stop bit, no gap.
//  4. DATA_VALID pulse and P_DATA=0xFF during the DATA state of a 0x3C frame ->
//     0x3C frame unchanged; no second frame.
//  5. RST=1 at the 4th data bit -> next edge TX_OUT=1, Busy=0;
//     next request sends a full clean frame.
//  6. STOP_BITS=2, DATA_WIDTH=7, 0x55, PAR_EN=0 -> 10-cycle frame;
//     Busy low only in the 2nd stop cycle.

Source files
------------

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
//   Serial UART transmitter. Accepts one parallel word and emits a framed
//   bitstream on TX_OUT, one bit per CLK: start bit (0), data bits LSB first,
//   optional parity bit, then STOP_BITS stop bits (1). The line idles high.
//   Parity matches the RX checker: PAR_TYP 0 = even, 1 = odd.
//
// Parameters
//   DATA_WIDTH  data bits per frame (5..9)
//   STOP_BITS   stop bits per frame (1 or 2)
//
// Ports
//   CLK         clock (baud tick clock), all logic on posedge
//   RST         synchronous active-high reset; abandons any frame in flight
//   P_DATA      parallel word to send
//   DATA_VALID  send request, only sampled while Busy = 0
//   PAR_EN      1 = append parity bit after the data bits
//   PAR_TYP     0 = even parity, 1 = odd parity
//   TX_OUT      serial line, registered, idles high
//   Busy        1 = frame in progress, requests are dropped
// -----------------------------------------------------------------------------
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);
  // With a single stop bit the first stop cycle is also the last one, so
  // Busy is already released when entering STOP.
  localparam logic STOP_ENTRY_BUSY = (STOP_BITS > 1);

  // Elaboration-time guard against unsupported parameter values.
  if ((DATA_WIDTH < 5) || (DATA_WIDTH > 9) || (STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_params
    $error("uart_tx_frame: DATA_WIDTH must be 5..9 and STOP_BITS 1..2");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // The state register names the bit currently on the line; every transition
  // also loads the value of the bit being entered, so TX_OUT comes straight
  // from a flop.
  state_t                  state_reg;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic                    par_en_reg;
  logic                    par_typ_reg;
  logic [CNT_W-1:0]        bit_cnt_reg;
  logic                    stop_cnt_reg;
  logic                    tx_out_reg;
  logic                    busy_reg;

  logic [CNT_W-1:0]        bit_cnt_next;
  logic                    stop_cnt_next;
  logic                    parity_bit;

  assign bit_cnt_next  = bit_cnt_reg + 1'b1;
  assign stop_cnt_next = stop_cnt_reg + 1'b1;
  assign parity_bit    = (^data_reg) ^ par_typ_reg;

  assign TX_OUT = tx_out_reg;
  assign Busy   = busy_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      data_reg     <= '0;
      par_en_reg   <= 1'b0;
      par_typ_reg  <= 1'b0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      tx_out_reg   <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (DATA_VALID) begin
            data_reg    <= P_DATA;
            par_en_reg  <= PAR_EN;
            par_typ_reg <= PAR_TYP;
            bit_cnt_reg <= '0;
            state_reg   <= START;
            tx_out_reg  <= 1'b0;
            busy_reg    <= 1'b1;
          end else begin
            tx_out_reg  <= 1'b1;
            busy_reg    <= 1'b0;
          end
        end

        START: begin
          bit_cnt_reg <= '0;
          state_reg   <= DATA;
          tx_out_reg  <= data_reg[0];
          busy_reg    <= 1'b1;
        end

        DATA: begin
          if (bit_cnt_reg == LAST_BIT) begin
            if (par_en_reg) begin
              state_reg    <= PARITY;
              tx_out_reg   <= parity_bit;
              busy_reg     <= 1'b1;
            end else begin
              state_reg    <= STOP;
              stop_cnt_reg <= 1'b0;
              tx_out_reg   <= 1'b1;
              busy_reg     <= STOP_ENTRY_BUSY;
            end
          end else begin
            bit_cnt_reg <= bit_cnt_next;
            tx_out_reg  <= data_reg[bit_cnt_next];
            busy_reg    <= 1'b1;
          end
        end

        PARITY: begin
          state_reg    <= STOP;
          stop_cnt_reg <= 1'b0;
          tx_out_reg   <= 1'b1;
          busy_reg     <= STOP_ENTRY_BUSY;
        end

        STOP: begin
          if (stop_cnt_reg == LAST_STOP) begin
            // Busy is low in this cycle, so a request here starts the next
            // frame with no idle gap.
            if (DATA_VALID) begin
              data_reg    <= P_DATA;
              par_en_reg  <= PAR_EN;
              par_typ_reg <= PAR_TYP;
              bit_cnt_reg <= '0;
              state_reg   <= START;
              tx_out_reg  <= 1'b0;
              busy_reg    <= 1'b1;
            end else begin
              state_reg   <= IDLE;
              tx_out_reg  <= 1'b1;
              busy_reg    <= 1'b0;
            end
          end else begin
            stop_cnt_reg <= stop_cnt_next;
            tx_out_reg   <= 1'b1;
            busy_reg     <= (stop_cnt_next != LAST_STOP);
          end
        end

        default: begin
          state_reg  <= IDLE;
          tx_out_reg <= 1'b1;
          busy_reg   <= 1'b0;
        end
      endcase
    end
  end

endmodule
